// File: rtl/stack_arbiter.sv
// rtl/stack_arbiter.sv - two-requester push/pop arbiter and sequencer for an 8x4 LIFO stack
module stack_arbiter #(
  parameter int DATA_W     = 4,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              op0,
  input  logic              op1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              busy,
  output logic              stk_push,
  output logic              stk_pop,
  output logic [DATA_W-1:0] stk_data_in,
  input  logic [DATA_W-1:0] stk_data_out,
  input  logic              stk_empty,
  input  logic              stk_full
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state;
  logic   owner;
  logic   op;
  logic   last_grant;

  logic              pick;
  logic              pick_op;
  logic [DATA_W-1:0] pick_data;
  logic              reject;

  // Owner selection and the full/empty check only matter in IDLE
  always_comb begin
    pick = 1'b0;
    if (req0 && req1) begin
      pick = FIXED_PRIO ? 1'b0 : ~last_grant;
    end else begin
      pick = req1;
    end
    pick_op   = pick ? op1 : op0;
    pick_data = pick ? wdata1 : wdata0;
    reject    = pick_op ? stk_empty : stk_full;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= 1'b0;
      op          <= 1'b0;
      last_grant  <= 1'b1;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      rdata       <= '0;
      err         <= 1'b0;
      busy        <= 1'b0;
      stk_push    <= 1'b0;
      stk_pop     <= 1'b0;
      stk_data_in <= '0;
    end else begin
      // Strobes and acks are single-cycle pulses
      stk_push <= 1'b0;
      stk_pop  <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner       <= pick;
            op          <= pick_op;
            last_grant  <= pick;
            stk_data_in <= pick_data;
            busy        <= 1'b1;
            if (reject) begin
              err   <= 1'b1;
              rdata <= '0;
              ack0  <= ~pick;
              ack1  <= pick;
              state <= RESP;
            end else begin
              stk_push <= ~pick_op;
              stk_pop  <= pick_op;
              state    <= ISSUE;
            end
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          rdata <= op ? stk_data_out : '0;
          err   <= 1'b0;
          ack0  <= ~owner;
          ack1  <= owner;
          state <= RESP;
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_arbiter.sv
// tb/tb_stack_arbiter.sv - randomized scoreboard bench for stack_arbiter against a queue-based reference
module tb_stack_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1, op0, op1;
  logic [3:0] wdata0, wdata1;
  logic       ack0, ack1, err, busy, stk_push, stk_pop;
  logic [3:0] rdata, stk_data_in, stk_data_out;
  logic       stk_empty, stk_full;

  logic       f_req0, f_req1, f_ack0, f_ack1, f_err, f_busy, f_stk_push, f_stk_pop;
  logic [3:0] f_rdata, f_stk_data_in, f_stk_data_out;
  logic       f_stk_empty, f_stk_full;

  always #5 clk = ~clk;

  stack_arbiter #(.DATA_W(4), .FIXED_PRIO(1'b0)) u_rr (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err), .busy(busy),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_data_in(stk_data_in),
    .stk_data_out(stk_data_out), .stk_empty(stk_empty), .stk_full(stk_full)
  );

  stack_arbiter #(.DATA_W(4), .FIXED_PRIO(1'b1)) u_fp (
    .clk(clk), .reset(reset),
    .req0(f_req0), .req1(f_req1), .op0(1'b0), .op1(1'b0),
    .wdata0(4'h6), .wdata1(4'h9),
    .ack0(f_ack0), .ack1(f_ack1), .rdata(f_rdata), .err(f_err), .busy(f_busy),
    .stk_push(f_stk_push), .stk_pop(f_stk_pop), .stk_data_in(f_stk_data_in),
    .stk_data_out(f_stk_data_out), .stk_empty(f_stk_empty), .stk_full(f_stk_full)
  );

  // Environment stacks: 8-deep LIFO, data_out registered on pop
  logic [3:0] mem [8];
  logic [3:0] cnt;
  always @(posedge clk) begin
    if (reset) begin
      cnt          <= 4'd0;
      stk_data_out <= 4'd0;
    end else if (stk_push && cnt < 4'd8) begin
      mem[cnt[2:0]] <= stk_data_in;
      cnt           <= cnt + 4'd1;
    end else if (stk_pop && cnt > 4'd0) begin
      stk_data_out <= mem[3'(cnt - 4'd1)];
      cnt          <= cnt - 4'd1;
    end
  end
  assign stk_empty = (cnt == 4'd0);
  assign stk_full  = (cnt == 4'd8);

  logic [3:0] f_cnt;
  always @(posedge clk) begin
    if (reset) begin
      f_cnt          <= 4'd0;
      f_stk_data_out <= 4'd0;
    end else if (f_stk_push && f_cnt < 4'd8) begin
      f_cnt <= f_cnt + 4'd1;
    end else if (f_stk_pop && f_cnt > 4'd0) begin
      f_cnt <= f_cnt - 4'd1;
    end
  end
  assign f_stk_empty = (f_cnt == 4'd0);
  assign f_stk_full  = (f_cnt == 4'd8);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain LIFO queue plus the last owner granted
  typedef struct {
    bit         who;
    bit         err;
    logic [3:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  bit   f_exp[$];
  int   ref_stk[$];
  bit   ref_last;

  function automatic bit predict(input bit who, input bit op, input logic [3:0] d);
    exp_t e;
    e.who   = who;
    e.err   = 1'b0;
    e.rdata = 4'd0;
    if (!op) begin
      if (ref_stk.size() == 8) e.err = 1'b1;
      else ref_stk.push_back(int'(d));
    end else begin
      if (ref_stk.size() == 0) e.err = 1'b1;
      else e.rdata = 4'(ref_stk.pop_back());
    end
    ref_last = who;
    exp_q.push_back(e);
    return e.err;
  endfunction

  function automatic logic [3:0] dat(input bit w, input int i);
    return 4'(int'(w) * 5 + i * 3 + 2);
  endfunction

  int         push_cnt = 0;
  int         pop_cnt  = 0;
  logic [3:0] last_din = 4'd0;
  exp_t       mon_e;

  always @(negedge clk) begin
    if (!reset) begin
      if (stk_push) begin
        push_cnt++;
        last_din = stk_data_in;
      end
      if (stk_pop) pop_cnt++;
      if (stk_push && stk_pop) check("strobe_exclusive", 1, 0);
      if (ack0 || ack1) begin
        check("ack_exclusive", {31'd0, ack0 && ack1}, 0);
        check("ack_expected", {31'd0, exp_q.size() > 0}, 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("ack_owner", {31'd0, ack1}, {31'd0, mon_e.who});
          check("resp_err", {31'd0, err}, {31'd0, mon_e.err});
          check("resp_rdata", {28'd0, rdata}, {28'd0, mon_e.rdata});
        end
      end
      if (f_ack0 || f_ack1) begin
        check("fp_ack_expected", {31'd0, f_exp.size() > 0}, 1);
        if (f_exp.size() > 0) check("fp_ack_owner", {31'd0, f_ack1}, {31'd0, f_exp.pop_front()});
      end
    end
  end

  task automatic do_single(input bit who, input bit op, input logic [3:0] d);
    bit rej;
    bit got;
    int n;
    int p0, q0;
    p0  = push_cnt;
    q0  = pop_cnt;
    rej = predict(who, op, d);
    if (who) begin req1 = 1'b1; op1 = op; wdata1 = d; end
    else     begin req0 = 1'b1; op0 = op; wdata0 = d; end
    got = 1'b0;
    n   = 0;
    while (!got && n < 10) begin
      @(posedge clk); #1;
      n++;
      if (who ? ack1 : ack0) got = 1'b1;
    end
    check("ack_seen", {31'd0, got}, 1);
    check("ack_latency", n, rej ? 1 : 3);
    req0 = 1'b0;
    req1 = 1'b0;
    check("push_strobes", push_cnt - p0, (!rej && !op) ? 1 : 0);
    check("pop_strobes", pop_cnt - q0, (!rej && op) ? 1 : 0);
    if (!rej && !op) check("push_data", {28'd0, last_din}, {28'd0, d});
    @(posedge clk); #1;
    check("idle_after_resp", {31'd0, busy}, 0);
  endtask

  // Both requesters hold req and push k ops each
  task automatic contend(input int k);
    int  p0, p1, idx0, idx1, n;
    bit  w;
    p0 = k;
    p1 = k;
    while (p0 > 0 || p1 > 0) begin
      if (p0 > 0 && p1 > 0) w = ~ref_last;
      else w = (p0 > 0) ? 1'b0 : 1'b1;
      if (w) begin void'(predict(1'b1, 1'b0, dat(1'b1, k - p1))); p1--; end
      else   begin void'(predict(1'b0, 1'b0, dat(1'b0, k - p0))); p0--; end
    end
    idx0 = 0; idx1 = 0; n = 0;
    op0 = 1'b0; op1 = 1'b0;
    wdata0 = dat(1'b0, 0); wdata1 = dat(1'b1, 0);
    req0 = 1'b1; req1 = 1'b1;
    while ((idx0 < k || idx1 < k) && n < 12 * k) begin
      @(posedge clk); #1;
      n++;
      if (ack0) begin
        idx0++;
        if (idx0 == k) req0 = 1'b0; else wdata0 = dat(1'b0, idx0);
      end
      if (ack1) begin
        idx1++;
        if (idx1 == k) req1 = 1'b0; else wdata1 = dat(1'b1, idx1);
      end
    end
    check("contend_done", {31'd0, idx0 == k && idx1 == k}, 1);
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int p0, n, acks;
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; op0 = 1'b0; op1 = 1'b0;
    wdata0 = 4'd0; wdata1 = 4'd0;
    f_req0 = 1'b0; f_req1 = 1'b0;
    ref_last = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ack", {30'd0, ack0, ack1}, 0);
    check("reset_strobes", {30'd0, stk_push, stk_pop}, 0);
    check("reset_err_busy", {30'd0, err, busy}, 0);
    check("reset_rdata", {28'd0, rdata}, 0);
    check("reset_data_in", {28'd0, stk_data_in}, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    do_single(1'b0, 1'b0, 4'hA);
    do_single(1'b1, 1'b1, 4'h0);
    do_single(1'b1, 1'b1, 4'h0);
    do_single(1'b0, 1'b0, 4'h3);
    do_single(1'b1, 1'b0, 4'h5);
    do_single(1'b0, 1'b1, 4'h0);
    do_single(1'b1, 1'b1, 4'h0);

    while (ref_stk.size() < 8) do_single(1'($urandom % 2), 1'b0, 4'($urandom));
    do_single(1'b0, 1'b0, 4'hC);
    do_single(1'b1, 1'b1, 4'h0);
    do_single(1'b1, 1'b0, 4'hD);
    while (ref_stk.size() > 0) do_single(1'($urandom % 2), 1'b1, 4'h0);
    do_single(1'b0, 1'b1, 4'h0);

    // Reset while the push sits in WAIT: no ack, no second strobe
    p0 = push_cnt;
    req0 = 1'b1; op0 = 1'b0; wdata0 = 4'h7;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("busy_in_wait", {31'd0, busy}, 1);
    reset = 1'b1; req0 = 1'b0;
    ref_stk.delete();
    ref_last = 1'b1;
    @(posedge clk); #1;
    check("reset_wait_idle", {31'd0, busy}, 0);
    check("reset_wait_noack", {30'd0, ack0, ack1}, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_wait_one_strobe", push_cnt - p0, 1);
    check("reset_wait_stack_clear", {31'd0, stk_empty}, 1);

    contend(2);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) < 2) contend(int'($urandom_range(1, 2)));
      else do_single(1'($urandom % 2), 1'($urandom_range(0, 9) >= 5), 4'($urandom));
    end

    // Fixed priority: req0 wins every tie while held
    f_exp = '{1'b0, 1'b0, 1'b0, 1'b1};
    f_req0 = 1'b1; f_req1 = 1'b1;
    acks = 0; n = 0;
    while (acks < 4 && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (f_ack0 || f_ack1) begin
        acks++;
        if (acks == 3) f_req0 = 1'b0;
        if (f_ack1) f_req1 = 1'b0;
      end
    end
    check("fp_ack_count", acks, 4);
    f_req0 = 1'b0; f_req1 = 1'b0;

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    check("fp_scoreboard_drained", f_exp.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
